cpu_ctrl_seq: RTL and testbench

Hard-wired control sequencer for the 32-bit CPU datapath. Steps the datapath through instruction fetch (T0–T2) and execute (T3–T6) for register-register ALU, multiply/divide, NOP and HALT. It replaces hand-driven strobes with one-cycle-per-step control generated from a state register and the IR contents. It sits beside `datapath`, and its outputs connect one-to-one to the datapath strobe inputs.

---
 rtl/cpu_ctrl_pkg.sv | 59 +++++
 rtl/cpu_ctrl_seq_if.sv | 31 +++
 rtl/ctrl_decode.sv | 30 +++
 rtl/cpu_ctrl_seq.sv | 142 ++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, ALU selects,
// sequencer states, instruction classes and IR field positions.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_OR   = 5'h06;
  localparam logic [4:0] OP_SHR  = 5'h07;
  localparam logic [4:0] OP_SHL  = 5'h08;
  localparam logic [4:0] OP_ROR  = 5'h09;
  localparam logic [4:0] OP_ROL  = 5'h0A;
  localparam logic [4:0] OP_MUL  = 5'h0F;
  localparam logic [4:0] OP_DIV  = 5'h10;
  localparam logic [4:0] OP_NOP  = 5'h1A;
  localparam logic [4:0] OP_HALT = 5'h1B;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SHR  = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_DIV  = 4'd10;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_T0     = 4'd1,
    ST_T1     = 4'd2,
    ST_T2     = 4'd3,
    ST_T3     = 4'd4,
    ST_T4     = 4'd5,
    ST_T5     = 4'd6,
    ST_T6     = 4'd7,
    ST_HALTED = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_MULDIV,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

  function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

endpackage

// File: rtl/cpu_ctrl_seq_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface cpu_ctrl_seq_if;
  import cpu_ctrl_pkg::*;

  logic        run;
  logic [31:0] ir;
  logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, LOin, HIin;
  logic [15:0] Rout;
  logic [15:0] Rin;
  logic [3:0]  alu_op;
  logic        instr_done;
  logic [15:0] instret;
  logic        halted;
  logic        illegal;

  modport master (
    input  run, ir,
    output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
    output Yin, Zin, Zlowout, Zhighout, LOin, HIin,
    output Rout, Rin, alu_op, instr_done, instret, halted, illegal
  );

  modport slave (
    output run, ir,
    input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
    input  Yin, Zin, Zlowout, Zhighout, LOin, HIin,
    input  Rout, Rin, alu_op, instr_done, instret, halted, illegal
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class and ALU function select.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class,
  output logic [3:0] alu_op
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_op   = ALU_NONE;
    case (opcode)
      OP_ADD:  begin op_class = CLS_ALU;    alu_op = ALU_ADD; end
      OP_SUB:  begin op_class = CLS_ALU;    alu_op = ALU_SUB; end
      OP_AND:  begin op_class = CLS_ALU;    alu_op = ALU_AND; end
      OP_OR:   begin op_class = CLS_ALU;    alu_op = ALU_OR;  end
      OP_SHR:  begin op_class = CLS_ALU;    alu_op = ALU_SHR; end
      OP_SHL:  begin op_class = CLS_ALU;    alu_op = ALU_SHL; end
      OP_ROR:  begin op_class = CLS_ALU;    alu_op = ALU_ROR; end
      OP_ROL:  begin op_class = CLS_ALU;    alu_op = ALU_ROL; end
      OP_MUL:  begin op_class = CLS_MULDIV; alu_op = ALU_MUL; end
      OP_DIV:  begin op_class = CLS_MULDIV; alu_op = ALU_DIV; end
      OP_NOP:  op_class = CLS_NOP;
      OP_HALT: op_class = CLS_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Hard-wired fetch/execute sequencer: one state per clock, Moore strobes
// decoded from the state register and the IR.
module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  cpu_ctrl_seq_if.master bus
);

  state_t      state, state_nxt;
  op_class_t   op_class;
  logic [3:0]  dec_alu_op;
  logic [3:0]  ra, rb, rc;
  logic [15:0] instret_q;
  logic        illegal_q;
  logic        unused_ir;

  assign ra        = bus.ir[RA_LSB +: 4];
  assign rb        = bus.ir[RB_LSB +: 4];
  assign rc        = bus.ir[RC_LSB +: 4];
  assign unused_ir = ^bus.ir[RC_LSB-1:0];

  ctrl_decode u_decode (
    .opcode   (bus.ir[OPC_LSB +: 5]),
    .op_class (op_class),
    .alu_op   (dec_alu_op)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = bus.run ? ST_T0 : ST_IDLE;
      ST_T0:   state_nxt = ST_T1;
      ST_T1:   state_nxt = ST_T2;
      ST_T2:   state_nxt = ST_T3;
      ST_T3: begin
        case (op_class)
          CLS_ALU, CLS_MULDIV: state_nxt = ST_T4;
          CLS_NOP:             state_nxt = bus.run ? ST_T0 : ST_IDLE;
          default:             state_nxt = ST_HALTED;
        endcase
      end
      ST_T4:   state_nxt = ST_T5;
      ST_T5: begin
        if (op_class == CLS_MULDIV) state_nxt = ST_T6;
        else                        state_nxt = bus.run ? ST_T0 : ST_IDLE;
      end
      ST_T6:     state_nxt = bus.run ? ST_T0 : ST_IDLE;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.PCout      = 1'b0;
    bus.MARin      = 1'b0;
    bus.IncPC      = 1'b0;
    bus.PCin       = 1'b0;
    bus.Read       = 1'b0;
    bus.MDRin      = 1'b0;
    bus.MDRout     = 1'b0;
    bus.IRin       = 1'b0;
    bus.Yin        = 1'b0;
    bus.Zin        = 1'b0;
    bus.Zlowout    = 1'b0;
    bus.Zhighout   = 1'b0;
    bus.LOin       = 1'b0;
    bus.HIin       = 1'b0;
    bus.Rout       = '0;
    bus.Rin        = '0;
    bus.alu_op     = ALU_NONE;
    bus.instr_done = 1'b0;
    case (state)
      ST_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      ST_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      ST_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      ST_T3: begin
        if (op_class == CLS_ALU || op_class == CLS_MULDIV) begin
          bus.Rout = reg_onehot(rb);
          bus.Yin  = 1'b1;
        end else if (op_class == CLS_NOP) begin
          bus.instr_done = 1'b1;
        end
      end
      ST_T4: begin
        bus.Rout   = reg_onehot(rc);
        bus.Zin    = 1'b1;
        bus.alu_op = dec_alu_op;
      end
      ST_T5: begin
        bus.Zlowout = 1'b1;
        // MUL/DIV moves the low word to LO here; the high word follows in T6
        if (op_class == CLS_MULDIV) begin
          bus.LOin = 1'b1;
        end else begin
          bus.Rin        = reg_onehot(ra);
          bus.instr_done = 1'b1;
        end
      end
      ST_T6: begin
        bus.Zhighout   = 1'b1;
        bus.HIin       = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (bus.instr_done) instret_q <= instret_q + 16'd1;
      if (state == ST_T3 && op_class == CLS_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  assign bus.instret = instret_q;
  assign bus.halted  = (state == ST_HALTED);
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: directed instructions from the test plan, then a
// randomized instruction stream checked against a per-instruction cycle list.
module tb_cpu_ctrl_seq;

  logic clk = 1'b0;
  logic clr;

  cpu_ctrl_seq_if bus ();

  cpu_ctrl_seq dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [13:0] S_PCOUT  = 14'h2000;
  localparam logic [13:0] S_MARIN  = 14'h1000;
  localparam logic [13:0] S_INCPC  = 14'h0800;
  localparam logic [13:0] S_PCIN   = 14'h0400;
  localparam logic [13:0] S_READ   = 14'h0200;
  localparam logic [13:0] S_MDRIN  = 14'h0100;
  localparam logic [13:0] S_MDROUT = 14'h0080;
  localparam logic [13:0] S_IRIN   = 14'h0040;
  localparam logic [13:0] S_YIN    = 14'h0020;
  localparam logic [13:0] S_ZIN    = 14'h0010;
  localparam logic [13:0] S_ZLO    = 14'h0008;
  localparam logic [13:0] S_ZHI    = 14'h0004;
  localparam logic [13:0] S_LOIN   = 14'h0002;
  localparam logic [13:0] S_HIIN   = 14'h0001;

  localparam logic [4:0] OPC_TAB [0:11] = '{5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08,
                                            5'h09, 5'h0A, 5'h0F, 5'h10, 5'h1A, 5'h1B};
  localparam logic [3:0] AOP_TAB [0:11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                            4'd7, 4'd8, 4'd9, 4'd10, 4'd0, 4'd0};

  typedef struct packed {
    logic [13:0] strb;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [3:0]  aop;
    logic        done;
    logic        hlt;
    logic        ill;
  } cyc_t;

  localparam cyc_t IDLE_C = '0;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] m_instret   = 16'd0;
  cyc_t        q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int find_op(input logic [4:0] opc);
    for (int i = 0; i < 12; i++) if (OPC_TAB[i] == opc) return i;
    return -1;
  endfunction

  // 0 ALU, 1 MUL/DIV, 2 NOP, 3 HALT, 4 undefined
  function automatic int op_kind(input logic [4:0] opc);
    int idx = find_op(opc);
    if (idx < 0)   return 4;
    if (idx < 8)   return 0;
    if (idx < 10)  return 1;
    if (idx == 10) return 2;
    return 3;
  endfunction

  function automatic cyc_t mk(input logic [13:0] s, input logic [15:0] ro, input logic [15:0] ri,
                              input logic [3:0] a, input logic d, input logic h, input logic il);
    return '{strb: s, rout: ro, rin: ri, aop: a, done: d, hlt: h, ill: il};
  endfunction

  function automatic cyc_t observe();
    return '{strb: {bus.PCout, bus.MARin, bus.IncPC, bus.PCin, bus.Read, bus.MDRin, bus.MDRout,
                    bus.IRin, bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout, bus.LOin, bus.HIin},
             rout: bus.Rout, rin: bus.Rin, aop: bus.alu_op, done: bus.instr_done,
             hlt: bus.halted, ill: bus.illegal};
  endfunction

  function automatic logic [31:0] pick_ir();
    logic [4:0] opc;
    int r = $urandom_range(0, 99);
    if (r < 3) opc = 5'h1B;
    else if (r < 6) begin
      opc = 5'($urandom_range(0, 31));
      while (find_op(opc) >= 0) opc = 5'($urandom_range(0, 31));
    end else opc = OPC_TAB[$urandom_range(0, 10)];
    return {opc, 27'($urandom)};
  endfunction

  // Expected per-cycle outputs of one instruction, starting at its fetch.
  task automatic build(input logic [31:0] irv);
    logic [4:0] opc = irv[31:27];
    logic [3:0] ra  = irv[26:23];
    logic [3:0] rb  = irv[22:19];
    logic [3:0] rc  = irv[18:15];
    int k = op_kind(opc);
    int idx = find_op(opc);
    q.delete();
    q.push_back(mk(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(S_ZLO | S_PCIN | S_READ | S_MDRIN, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(S_MDROUT | S_IRIN, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0));
    if (k <= 1) begin
      q.push_back(mk(S_YIN, 16'd1 << rb, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0));
      q.push_back(mk(S_ZIN, 16'd1 << rc, 16'h0, AOP_TAB[idx], 1'b0, 1'b0, 1'b0));
      if (k == 0) begin
        q.push_back(mk(S_ZLO, 16'h0, 16'd1 << ra, 4'd0, 1'b1, 1'b0, 1'b0));
      end else begin
        q.push_back(mk(S_ZLO | S_LOIN, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(S_ZHI | S_HIIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0));
      end
    end else if (k == 2) begin
      q.push_back(mk(14'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0));
    end else begin
      q.push_back(IDLE_C);
    end
  endtask

  task automatic check_now(input cyc_t exp, input string tag);
    cyc_t obs = observe();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: outputs observed %h expected %h", tag, obs, exp);
    end
    vectors++;
    assert (bus.instret === m_instret) else begin
      miscompares++;
      $error("FAIL %s_instret: observed %h expected %h", tag, bus.instret, m_instret);
    end
  endtask

  // Called at a falling edge: check this cycle, drive run, advance one clock.
  task automatic step(input cyc_t exp, input logic run_v, input string tag);
    check_now(exp, tag);
    bus.run = run_v;
    @(negedge clk);
    if (exp.done) m_instret = m_instret + 16'd1;
  endtask

  task automatic do_instr(input logic [31:0] irv, input logic run_end, input int halt_cycles);
    int k = op_kind(irv[31:27]);
    int n;
    bus.ir = irv;
    build(irv);
    n = q.size();
    for (int i = 0; i < n; i++)
      step(q[i], (i == n - 1) ? run_end : 1'($urandom_range(0, 1)),
           $sformatf("op%02h_c%0d", irv[31:27], i));
    if (k >= 3)
      for (int i = 0; i < halt_cycles; i++)
        step(mk(14'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b1, k == 4), 1'b1,
             $sformatf("halted%02h_%0d", irv[31:27], i));
  endtask

  task automatic idle_go(input int extra);
    for (int i = 0; i < extra; i++) step(IDLE_C, 1'b0, "idle_wait");
    step(IDLE_C, 1'b1, "idle_go");
  endtask

  task automatic do_reset(input string tag);
    #2 clr = 1'b1;
    m_instret = 16'd0;
    #1 check_now(IDLE_C, {tag, "_async"});
    @(negedge clk);
    check_now(IDLE_C, {tag, "_held"});
    clr = 1'b0;
  endtask

  initial begin
    logic [31:0] irv;
    logic        re;
    int          k;

    clr    = 1'b1;
    bus.run = 1'b0;
    bus.ir  = 32'h0;
    @(negedge clk);
    check_now(IDLE_C, "reset_state");
    @(negedge clk);
    clr = 1'b0;
    idle_go(1);

    // AND R1,R2,R3 then SUB R1,R2,R3 back to back, stopping afterwards
    do_instr(32'h28918000, 1'b1, 0);
    do_instr(32'h20918000, 1'b0, 0);
    idle_go(2);
    do_instr(32'h78118000, 1'b1, 0);
    do_instr(32'hD0000000, 1'b1, 0);

    // reset in the middle of an ADD's T4
    bus.ir = 32'h18918000;
    build(32'h18918000);
    for (int i = 0; i < 4; i++) step(q[i], 1'b1, $sformatf("add_pre_clr_c%0d", i));
    check_now(q[4], "add_t4");
    do_reset("clr_mid_t4");
    bus.run = 1'b1;
    step(IDLE_C, 1'b1, "post_clr_idle");
    do_instr(32'h18918000, 1'b1, 0);

    do_instr(32'hD8000000, 1'b1, 20);
    do_reset("clr_halt");
    idle_go(0);
    do_instr(32'hD0000000, 1'b1, 0);
    do_instr(32'hF8000000, 1'b1, 5);
    do_reset("clr_illegal");
    idle_go(0);

    for (int n = 0; n < 150; n++) begin
      irv = pick_ir();
      re  = 1'($urandom_range(0, 3) != 0);
      k   = op_kind(irv[31:27]);
      do_instr(irv, re, 3);
      if (k >= 3) begin
        do_reset("rand_clr");
        idle_go(0);
      end else if (!re) begin
        idle_go($urandom_range(0, 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
